startup_display_seq: RTL and testbench
======================================

Name: startup_display_seq

Overview:
- Parametrised front-panel/LED startup display sequencer.
- Steps an internal pattern address through N_PAT patterns, holding each for DWELL clocks with an internal dwell timer. Repeats the walk LOOPS times, or forever when LOOPS=0.
- Adds hold, abort and re-arm on top of the basic load/wait/next cycle.
- Sits between the power-up controller (RUN) and the display pattern ROM/driver, which consumes ADR, NXT_ADR, LOAD_PAT, CLEAR and DISP.

Parameters:
- N_PAT, 8: number of patterns; legal range 2..2^ADR_W.
- ADR_W, 3: pattern address width.
- TMR_W, 16: dwell timer width.
- DWELL, 3000: clocks each pattern is held in Wait; legal range 1..2^TMR_W-1.
- SETTLE, 1: clocks between NXT_ADR and LOAD_PAT (ROM access settle); legal range 1..15.
- LOOPS, 1: number of full pattern walks; 0 = run until ABORT; legal range 0..255.

Ports:
- CLK, input, 1: system clock.
- RST, input, 1: asynchronous active-high reset.
- RUN, input, 1: level; start sequence when 1 in Idle; must be 0 to re-arm from End.
- HOLD, input, 1: level; freezes dwell timer while 1.
- ABORT, input, 1: pulse; terminate sequence.
- ADR, output, ADR_W: current pattern address, registered.
- NXT_ADR, output, 1: one-clock pulse when ADR advances.
- LOAD_PAT, output, 1: one-clock pulse; driver latches pattern at ADR.
- CLEAR, output, 1: blank display.
- DISP, output, 1: display enable.
- BUSY, output, 1: sequence in progress.
- FINISHED, output, 1: sequence complete or aborted.

Behaviour:
- Decided interface: one clock CLK; reset RST is asynchronous, active-high.
- All outputs are registered and decoded from the next state, so they are valid in the first cycle of each state.
- States: Idle, Load, Wait, Next, Settle, End.
- Reset (async, any time, including mid-sequence):
  - state=Idle; ADR=0; timer=0; settle count=0; loop count=0.
  - CLEAR=1, DISP=0, NXT_ADR=0, LOAD_PAT=0, BUSY=0, FINISHED=0.
- Idle:
  - CLEAR=1, DISP=0.
  - ABORT=1 -> stay Idle (ABORT has priority over RUN).
  - else RUN=1 -> Load, with ADR=0 and loop count=0.
  - else stay Idle.
- Load (1 clock): LOAD_PAT=1, DISP=1 -> Wait.
- Wait:
  - DISP=1.
  - Timer starts at 0 on entry and increments each clock when HOLD=0; it does not increment when HOLD=1.
  - Exit when timer==DWELL-1 and HOLD=0, so Wait lasts DWELL clocks plus hold clocks.
  - On exit:
    - if ADR==N_PAT-1 and (LOOPS!=0 and loop count==LOOPS-1) -> End;
    - else -> Next.
- Next (1 clock):
  - NXT_ADR=1, DISP=1.
  - ADR increments in the same registered update.
  - ADR wraps from N_PAT-1 to 0; on wrap, loop count increments, saturating at 255.
  - -> Settle.
- Settle: DISP=1; lasts SETTLE clocks -> Load. HOLD has no effect here.
- End:
  - CLEAR=1, DISP=0, FINISHED=1.
  - RUN=0 -> Idle (FINISHED drops); else stay End.
- BUSY=1 in Load, Wait, Next and Settle.
- ABORT=1 in Load/Wait/Next/Settle -> End next clock, overriding all other transitions. ADR holds its value; no NXT_ADR or LOAD_PAT is issued that cycle.
- ABORT in End is ignored.
- RUN deasserting mid-sequence is ignored; only ABORT or RST stops the sequence.
- Pattern period after the first pattern: 1+DWELL+1+SETTLE clocks.

Test Plan:
- Nominal run (N_PAT=3, DWELL=4, SETTLE=2, LOOPS=2), RUN=1 sampled at edge 0:
  - LOAD_PAT at cycles 1, 9, 17, 25, 33, 41 with ADR=0, 1, 2, 0, 1, 2.
  - NXT_ADR 5 times, at cycles 6, 14, 22, 30, 38.
  - End entered at cycle 46: FINISHED=1, CLEAR=1, DISP=0, BUSY=0.
- HOLD=1 for 3 clocks in the first Wait (same params): first NXT_ADR moves from cycle 6 to 9; all later events shift +3.
- ABORT pulse at cycle 7 (Settle): End at cycle 8; ADR stays 1; no LOAD_PAT at cycle 9; FINISHED=1.
- LOOPS=0, N_PAT=2: ADR toggles 0,1,0,1 for >=5 walks with no End; ABORT -> End next clock. RUN=0 then -> Idle; RUN=1 -> LOAD_PAT with ADR=0.
- RST asserted mid-Wait (cycle 3): outputs return to reset values with no clock edge. After release with RUN held at 1, the sequence restarts at ADR=0.
- Idle with RUN=1 and ABORT=1 in the same cycle: stays Idle, BUSY=0. Next cycle with ABORT=0: Load.

Source files
------------

// File: rtl/startup_display_seq.sv
// Front-panel startup display sequencer: walks N_PAT patterns, holding each for DWELL
// clocks, LOOPS times (0 = until ABORT), with HOLD freeze, ABORT and re-arm via RUN.
module startup_display_seq #(
    parameter int N_PAT  = 8,
    parameter int ADR_W  = 3,
    parameter int TMR_W  = 16,
    parameter int DWELL  = 3000,
    parameter int SETTLE = 1,
    parameter int LOOPS  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic             HOLD,
    input  logic             ABORT,
    output logic [ADR_W-1:0] ADR,
    output logic             NXT_ADR,
    output logic             LOAD_PAT,
    output logic             CLEAR,
    output logic             DISP,
    output logic             BUSY,
    output logic             FINISHED
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_NEXT,
        S_SETTLE,
        S_END
    } state_t;

    localparam logic [ADR_W-1:0] ADR_LAST    = ADR_W'(N_PAT - 1);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(DWELL - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0]       LOOP_LAST   = 8'(LOOPS - 1);
    localparam bit               ENDLESS     = (LOOPS == 0);

    state_t           state, nxt_state;
    logic [TMR_W-1:0] timer;
    logic [3:0]       settle_cnt;
    logic [7:0]       loop_cnt;
    logic             dwell_done, settle_done, last_walk, in_seq;
    logic             nxt_adr_d, load_pat_d, clear_d, disp_d, busy_d, finished_d;

    assign dwell_done  = (timer == TMR_LAST) && !HOLD;
    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign last_walk   = (ADR == ADR_LAST) && !ENDLESS && (loop_cnt == LOOP_LAST);
    assign in_seq      = (state == S_LOAD) || (state == S_WAIT) ||
                         (state == S_NEXT) || (state == S_SETTLE);

    // State and output registers; outputs are decoded from nxt_state so they line up with the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            NXT_ADR  <= 1'b0;
            LOAD_PAT <= 1'b0;
            CLEAR    <= 1'b1;
            DISP     <= 1'b0;
            BUSY     <= 1'b0;
            FINISHED <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples pre-edge values regardless of order.
            state    <= nxt_state;
            NXT_ADR  <= nxt_adr_d;
            LOAD_PAT <= load_pat_d;
            CLEAR    <= clear_d;
            DISP     <= disp_d;
            BUSY     <= busy_d;
            FINISHED <= finished_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves nxt_state unassigned (no latch).
        nxt_state = state;
        case (state)
            S_IDLE:   if (!ABORT && RUN) nxt_state = S_LOAD;
            S_LOAD:   nxt_state = S_WAIT;
            S_WAIT:   if (dwell_done) nxt_state = last_walk ? S_END : S_NEXT;
            S_NEXT:   nxt_state = S_SETTLE;
            S_SETTLE: if (settle_done) nxt_state = S_LOAD;
            S_END:    if (!RUN) nxt_state = S_IDLE;
            default:  nxt_state = S_IDLE;
        endcase
        if (ABORT && in_seq) nxt_state = S_END;
    end

    always_comb begin
        nxt_adr_d  = 1'b0;
        load_pat_d = 1'b0;
        clear_d    = 1'b0;
        disp_d     = 1'b0;
        busy_d     = 1'b0;
        finished_d = 1'b0;
        case (nxt_state)
            S_LOAD:   begin load_pat_d = 1'b1; disp_d = 1'b1; busy_d = 1'b1; end
            S_WAIT:   begin disp_d = 1'b1; busy_d = 1'b1; end
            S_NEXT:   begin nxt_adr_d = 1'b1; disp_d = 1'b1; busy_d = 1'b1; end
            S_SETTLE: begin disp_d = 1'b1; busy_d = 1'b1; end
            S_END:    begin clear_d = 1'b1; finished_d = 1'b1; end
            default:  clear_d = 1'b1;
        endcase
    end

    // Timers restart from zero on every state entry; HOLD only freezes the dwell timer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ADR        <= '0;
            timer      <= '0;
            settle_cnt <= '0;
            loop_cnt   <= '0;
        end else begin
            if (state == S_WAIT && nxt_state == S_WAIT)
                timer <= HOLD ? timer : timer + TMR_W'(1);
            else
                timer <= '0;

            if (state == S_SETTLE && nxt_state == S_SETTLE)
                settle_cnt <= settle_cnt + 4'd1;
            else
                settle_cnt <= '0;

            if (state == S_IDLE && nxt_state == S_LOAD) begin
                ADR      <= '0;
                loop_cnt <= '0;
            end else if (nxt_state == S_NEXT) begin
                if (ADR == ADR_LAST) begin
                    ADR <= '0;
                    if (loop_cnt != 8'hFF) loop_cnt <= loop_cnt + 8'd1;
                end else begin
                    ADR <= ADR + ADR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_startup_display_seq.sv
// Directed bench for startup_display_seq: table-driven cycle checkpoints on a finite-loop
// instance plus hand sequences for reset, abort, Idle priority and an endless-loop instance.
module tb_startup_display_seq;

    // Flag vector order: {NXT_ADR, LOAD_PAT, CLEAR, DISP, BUSY, FINISHED}
    localparam logic [5:0] F_IDLE = 6'b001000;
    localparam logic [5:0] F_LOAD = 6'b010110;
    localparam logic [5:0] F_WAIT = 6'b000110;
    localparam logic [5:0] F_NEXT = 6'b100110;
    localparam logic [5:0] F_SETL = 6'b000110;
    localparam logic [5:0] F_END  = 6'b001001;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       a_run = 1'b0, a_hold = 1'b0, a_abort = 1'b0;
    logic       b_run = 1'b0, b_hold = 1'b0, b_abort = 1'b0;
    logic [2:0] a_adr, b_adr;
    logic       a_nxt, a_load, a_clear, a_disp, a_busy, a_fin;
    logic       b_nxt, b_load, b_clear, b_disp, b_busy, b_fin;
    logic [5:0] a_flags, b_flags;

    assign a_flags = {a_nxt, a_load, a_clear, a_disp, a_busy, a_fin};
    assign b_flags = {b_nxt, b_load, b_clear, b_disp, b_busy, b_fin};

    always #5 CLK = ~CLK;

    startup_display_seq #(.N_PAT(3), .ADR_W(3), .TMR_W(16), .DWELL(4), .SETTLE(2), .LOOPS(2)) dut_a (
        .CLK(CLK), .RST(RST), .RUN(a_run), .HOLD(a_hold), .ABORT(a_abort),
        .ADR(a_adr), .NXT_ADR(a_nxt), .LOAD_PAT(a_load), .CLEAR(a_clear),
        .DISP(a_disp), .BUSY(a_busy), .FINISHED(a_fin)
    );

    startup_display_seq #(.N_PAT(2), .ADR_W(3), .TMR_W(16), .DWELL(4), .SETTLE(2), .LOOPS(0)) dut_b (
        .CLK(CLK), .RST(RST), .RUN(b_run), .HOLD(b_hold), .ABORT(b_abort),
        .ADR(b_adr), .NXT_ADR(b_nxt), .LOAD_PAT(b_load), .CLEAR(b_clear),
        .DISP(b_disp), .BUSY(b_busy), .FINISHED(b_fin)
    );

    // One checkpoint: expected outputs in cycle cyc, then inputs driven until the next checkpoint.
    typedef struct {
        int         cyc;
        logic       run;
        logic       hold;
        logic       abort;
        logic [2:0] adr;
        logic [5:0] flags;
    } vec_t;

    vec_t tbl[32];
    int   n_tbl = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   load_seen = 0;
    int   nxt_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int c, input logic r, input logic h, input logic ab,
                       input logic [2:0] adr, input logic [5:0] fl);
        tbl[n_tbl] = '{cyc: c, run: r, hold: h, abort: ab, adr: adr, flags: fl};
        n_tbl++;
    endtask

    // Cycle k is the interval after edge k-1; outputs are sampled at its falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        if (a_load) load_seen++;
        if (a_nxt)  nxt_seen++;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST     = 1'b1;
        a_run   = 1'b0;
        a_hold  = 1'b0;
        a_abort = 1'b0;
        b_run   = 1'b0;
        b_abort = 1'b0;
        @(negedge CLK);
        check("reset adr", 32'(a_adr), 32'(3'd0));
        check("reset flags", 32'(a_flags), 32'(F_IDLE));
        RST   = 1'b0;
        n_tbl = 0;
    endtask

    task automatic start();
        a_run     = 1'b1;
        cyc       = 0;
        load_seen = 0;
        nxt_seen  = 0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < n_tbl; i++) begin
            while (cyc < tbl[i].cyc) step();
            check($sformatf("%s c%0d adr", tag, cyc), 32'(a_adr), 32'(tbl[i].adr));
            check($sformatf("%s c%0d flags", tag, cyc), 32'(a_flags), 32'(tbl[i].flags));
            a_run   = tbl[i].run;
            a_hold  = tbl[i].hold;
            a_abort = tbl[i].abort;
        end
    endtask

    task automatic rst_mid(input int at, input logic [2:0] pre_adr);
        do_reset();
        start();
        while (cyc < at) step();
        check($sformatf("rst@%0d pre adr", at), 32'(a_adr), 32'(pre_adr));
        check($sformatf("rst@%0d pre flags", at), 32'(a_flags), 32'(F_WAIT));
        RST = 1'b1;
        #1;
        check($sformatf("rst@%0d async adr", at), 32'(a_adr), 32'(3'd0));
        check($sformatf("rst@%0d async flags", at), 32'(a_flags), 32'(F_IDLE));
        @(negedge CLK);
        RST = 1'b0;
        step();
        check($sformatf("rst@%0d restart adr", at), 32'(a_adr), 32'(3'd0));
        check($sformatf("rst@%0d restart flags", at), 32'(a_flags), 32'(F_LOAD));
    endtask

    initial begin
        int   b_loads;
        logic b_fin_seen;

        // Nominal two-walk run over three patterns.
        do_reset();
        add(1,  1, 0, 0, 3'd0, F_LOAD);
        add(2,  1, 0, 0, 3'd0, F_WAIT);
        add(5,  1, 0, 0, 3'd0, F_WAIT);
        add(6,  1, 0, 0, 3'd1, F_NEXT);
        add(7,  1, 0, 0, 3'd1, F_SETL);
        add(8,  1, 0, 0, 3'd1, F_SETL);
        add(9,  1, 0, 0, 3'd1, F_LOAD);
        add(14, 1, 0, 0, 3'd2, F_NEXT);
        add(17, 1, 0, 0, 3'd2, F_LOAD);
        add(22, 1, 0, 0, 3'd0, F_NEXT);
        add(25, 1, 0, 0, 3'd0, F_LOAD);
        add(30, 1, 0, 0, 3'd1, F_NEXT);
        add(33, 1, 0, 0, 3'd1, F_LOAD);
        add(38, 1, 0, 0, 3'd2, F_NEXT);
        add(41, 1, 0, 0, 3'd2, F_LOAD);
        add(45, 1, 0, 0, 3'd2, F_WAIT);
        add(46, 1, 0, 0, 3'd2, F_END);
        add(47, 0, 0, 0, 3'd2, F_END);
        add(48, 0, 0, 0, 3'd2, F_IDLE);
        start();
        run_table("nom");
        check("nom load count", 32'(load_seen), 32'd6);
        check("nom nxt count", 32'(nxt_seen), 32'd5);

        // HOLD over three Wait edges shifts every later event by three cycles.
        do_reset();
        add(1,  1, 0, 0, 3'd0, F_LOAD);
        add(2,  1, 1, 0, 3'd0, F_WAIT);
        add(5,  1, 0, 0, 3'd0, F_WAIT);
        add(6,  1, 0, 0, 3'd0, F_WAIT);
        add(8,  1, 0, 0, 3'd0, F_WAIT);
        add(9,  1, 0, 0, 3'd1, F_NEXT);
        add(10, 1, 0, 0, 3'd1, F_SETL);
        add(12, 1, 0, 0, 3'd1, F_LOAD);
        add(17, 1, 0, 0, 3'd2, F_NEXT);
        add(25, 1, 0, 0, 3'd0, F_NEXT);
        add(28, 1, 0, 0, 3'd0, F_LOAD);
        add(44, 1, 0, 0, 3'd2, F_LOAD);
        add(48, 1, 0, 0, 3'd2, F_WAIT);
        add(49, 0, 0, 0, 3'd2, F_END);
        add(50, 0, 0, 0, 3'd2, F_IDLE);
        start();
        run_table("hold");
        check("hold load count", 32'(load_seen), 32'd6);
        check("hold nxt count", 32'(nxt_seen), 32'd5);

        // ABORT in Settle; a second ABORT while in End is ignored.
        do_reset();
        add(1,  1, 0, 0, 3'd0, F_LOAD);
        add(6,  1, 0, 0, 3'd1, F_NEXT);
        add(7,  1, 0, 1, 3'd1, F_SETL);
        add(8,  1, 0, 1, 3'd1, F_END);
        add(9,  0, 0, 0, 3'd1, F_END);
        add(10, 0, 0, 0, 3'd1, F_IDLE);
        start();
        run_table("abort");
        check("abort load count", 32'(load_seen), 32'd1);
        check("abort nxt count", 32'(nxt_seen), 32'd1);

        // Asynchronous reset mid-Wait, in the first and the second pattern.
        rst_mid(3, 3'd0);
        rst_mid(11, 3'd1);

        // ABORT beats RUN in Idle.
        do_reset();
        a_run   = 1'b1;
        a_abort = 1'b1;
        step();
        check("idle abort flags", 32'(a_flags), 32'(F_IDLE));
        a_abort = 1'b0;
        step();
        check("idle release adr", 32'(a_adr), 32'(3'd0));
        check("idle release flags", 32'(a_flags), 32'(F_LOAD));

        // Endless walk over two patterns, then ABORT, re-arm and restart.
        do_reset();
        b_run      = 1'b1;
        b_loads    = 0;
        b_fin_seen = 1'b0;
        for (int c = 1; c <= 106; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (b_load) b_loads++;
            if (b_fin)  b_fin_seen = 1'b1;
            if ((c - 1) % 8 == 0) begin
                check($sformatf("endless c%0d load", c), 32'(b_load), 32'd1);
                check($sformatf("endless c%0d adr", c), 32'(b_adr), 32'(((c - 1) / 8) % 2));
            end
        end
        check("endless load count", 32'(b_loads), 32'd14);
        check("endless no finish", 32'(b_fin_seen), 32'd0);
        b_abort = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("endless abort flags", 32'(b_flags), 32'(F_END));
        check("endless abort adr", 32'(b_adr), 32'(3'd1));
        b_abort = 1'b0;
        b_run   = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("endless rearm flags", 32'(b_flags), 32'(F_IDLE));
        b_run = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("endless restart flags", 32'(b_flags), 32'(F_LOAD));
        check("endless restart adr", 32'(b_adr), 32'(3'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
